ram_sdp_arbiter: RTL and testbench
==================================

Name: ram_sdp_arbiter

Overview:
- Shares one simple dual-port RAM (ram_sdp) between NUM_PORTS requesters.
- Independent round-robin arbitration on the read port and the write port.
- Drives the RAM's rd/wr ports directly.
- Routes each read response back to the requester that issued it, with a fixed latency.
- Sits between client engines and a ram_sdp instance in the same clock domain.

Parameters:
- NUM_PORTS, 4: number of requesters (2..16).
- DATA_WIDTH, 16: RAM word width.
- ADDR_WIDTH, 10: RAM address width.
- REG_RD_DATA, 1'b1: must match the attached ram_sdp; read latency = 1 + REG_RD_DATA.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req  in  NUM_PORTS  per-requester read request; held until granted
- rd_addr  in  NUM_PORTS x ADDR_WIDTH  per-requester read address
- rd_gnt  out  NUM_PORTS  one-hot read grant, same cycle as accepted request
- rd_valid  out  NUM_PORTS  one-hot response valid
- rd_data  out  DATA_WIDTH  response data, broadcast to all requesters
- wr_req  in  NUM_PORTS  per-requester write request
- wr_addr  in  NUM_PORTS x ADDR_WIDTH  write address
- wr_data  in  NUM_PORTS x DATA_WIDTH  write data
- wr_gnt  out  NUM_PORTS  one-hot write grant; write is committed on the granted cycle
- ram_rd_en  out  1  to ram_sdp rd_en
- ram_rd_addr  out  ADDR_WIDTH  to ram_sdp rd_addr
- ram_rd_data  in  DATA_WIDTH  from ram_sdp rd_data
- ram_wr_en  out  1  to ram_sdp wr_en
- ram_wr_addr  out  ADDR_WIDTH  to ram_sdp wr_addr
- ram_wr_data  out  DATA_WIDTH  to ram_sdp wr_data

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: rd_valid=0 and both priority pointers=0. Grants and RAM enables are combinational and are 0 while no requests are present.
- Arbitration is combinational per port.
  - Search starts at the pointer and wraps modulo NUM_PORTS.
  - The first asserted req receives the one-hot gnt.
  - On a grant to index g, the pointer becomes (g+1) mod NUM_PORTS on the next edge.
  - With no grant, the pointer holds.
- Read and write arbiters are fully independent; a single requester may be granted read and write in the same cycle.
- Write port:
  - ram_wr_en = |wr_req.
  - ram_wr_addr/ram_wr_data = the granted requester's fields; zero when idle.
- Read issue: on a grant to g, ram_rd_addr = rd_addr[g].
- Response pipeline: shift register of depth L = 1 + REG_RD_DATA carrying {valid, id}.
  - Stage 0 loads {|rd_req, g}.
  - rd_valid = onehot(id) when the last stage is valid; otherwise 0.
  - rd_data = ram_rd_data (passthrough).
- Latency: a grant at cycle t produces rd_valid at edge t+L.
- Pipeline advance: ram_sdp's output register only advances on rd_en.
  - ram_rd_en = |rd_req OR (any valid in stages 0..L-2).
  - Reads issued only for advance use ram_rd_addr = 0; their results are untracked and never flagged valid.
- Back-to-back: one read grant per cycle. Full throughput of 1 response/cycle is required.
- No backpressure on responses: requesters must accept rd_valid unconditionally.
- Read-during-write to the same address: result follows the attached RAM's WRITE_FIRST setting. The arbiter adds no forwarding.
- Reset mid-operation: all in-flight responses are discarded (no rd_valid after reset). The RAM contents are untouched.
- A request that deasserts before it is granted is legal and is dropped.

Optional Feature:
- RAM_ARB_PERF_CNT_EN
  - Defined:
    - Adds per-requester 32-bit rd_grant_cnt and wr_grant_cnt output arrays, plus a 32-bit rd_conflict_cnt (cycles with >1 rd_req asserted).
    - All counters reset to 0 and saturate at 2^32-1.
  - Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ram_arb_pkg:
  - function rr_select(req, ptr) returning a one-hot grant.
  - function onehot_to_idx.
  - typedef rsp_tag_t {logic valid; logic [$clog2(NUM_PORTS)-1:0] id} (parameterized via localparam in the module).
- Sub-module rr_arbiter (NUM_PORTS): combinational grant plus a registered pointer with rst, instantiated twice (read, write).

Test Plan:
- NUM_PORTS=4, REG_RD_DATA=1, only rd_req[2] with addr 0x10 (RAM preloaded 0xBEEF) -> rd_gnt=4'b0100 in the same cycle; rd_valid=4'b0100 and rd_data=0xBEEF exactly 2 cycles later.
- All four rd_req held for 8 cycles, pointer at 0 -> grants 0,1,2,3,0,1,2,3; responses are in the same order with L=2 and no bubbles.
- wr_req[1] writes 0x1234 to addr 5 and wr_req[3] writes 0x5678 to addr 6 in the same cycle -> port 1 is granted first, port 3 next cycle; later reads return 0x1234 / 0x5678.
- Single read granted, then rd_req idle -> ram_rd_en stays 1 for one extra cycle, and rd_valid arrives on time (REG_RD_DATA=1). Repeat with REG_RD_DATA=0 -> latency is 1.
- rst asserted one cycle after a read grant -> no rd_valid is produced, and the pointers return to 0 (the next contended grant goes to port 0).
- With RAM_ARB_PERF_CNT_EN, 10 cycles with ports 0 and 1 both requesting reads -> rd_grant_cnt[0]=5, rd_grant_cnt[1]=5, rd_conflict_cnt=10.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and helpers for ram_sdp_arbiter.
//   MAX_PORTS / MAX_ID_W : widest requester count the helpers handle (16).
//   rr_select            : round-robin pick; returns a one-hot grant.
//   onehot_to_idx        : encodes a one-hot vector as a binary index.
package ram_arb_pkg;

  localparam int MAX_PORTS = 16;
  localparam int MAX_ID_W  = 4;

  // Scan n requesters starting at ptr, wrapping at n; the first asserted
  // request wins. ptr must be < n. Bits at and above n are ignored.
  function automatic logic [MAX_PORTS-1:0] rr_select(
    input logic [MAX_PORTS-1:0] req,
    input logic [MAX_ID_W-1:0]  ptr,
    input int                   n
  );
    logic [MAX_PORTS-1:0] gnt;
    logic                 found;
    logic [MAX_ID_W:0]    idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (i < n) begin
        idx = {1'b0, ptr} + 5'(i);
        if (idx >= 5'(n)) idx = idx - 5'(n);
        if (!found && req[idx[MAX_ID_W-1:0]]) begin
          gnt[idx[MAX_ID_W-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a registered priority
// pointer. After granting index g the pointer moves to (g+1) mod NUM_PORTS;
// it holds when nothing is requested.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   req      : per-requester request
//   gnt      : one-hot grant, same cycle as req
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [MAX_PORTS-1:0] req_ext, gnt_ext;
  logic [MAX_ID_W-1:0]  ptr_ext, gnt_idx;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_PORTS-1:0]   = req;
    ptr_ext                  = '0;
    ptr_ext[PTR_W-1:0]       = ptr_q;
    gnt_ext                  = rr_select(req_ext, ptr_ext, NUM_PORTS);
    gnt                      = gnt_ext[NUM_PORTS-1:0];
    gnt_idx                  = onehot_to_idx(gnt_ext);
    ptr_d                    = ptr_q;
    if (|req) begin
      ptr_d = (gnt_idx == MAX_ID_W'(NUM_PORTS - 1)) ? '0 : PTR_W'(gnt_idx + 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_sdp_arbiter.sv
// ram_sdp_arbiter: shares one simple dual-port RAM between NUM_PORTS
// requesters with independent round-robin arbiters on the read and write
// ports, and routes each read response back to its issuer after a fixed
// latency of L = 1 + REG_RD_DATA cycles.
//   rd_req/rd_addr -> rd_gnt (same cycle), rd_valid/rd_data (L cycles later)
//   wr_req/wr_addr/wr_data -> wr_gnt; write committed on the granted cycle
//   ram_rd_* / ram_wr_* : direct connection to the ram_sdp instance
// Optional: define RAM_ARB_PERF_CNT_EN to add rd_grant_cnt, wr_grant_cnt
// (per requester) and rd_conflict_cnt saturating 32-bit counters.
module ram_sdp_arbiter
  import ram_arb_pkg::*;
#(
  parameter int   NUM_PORTS   = 4,
  parameter int   DATA_WIDTH  = 16,
  parameter int   ADDR_WIDTH  = 10,
  parameter logic REG_RD_DATA = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 rd_req,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]                 rd_gnt,
  output logic [NUM_PORTS-1:0]                 rd_valid,
  output logic [DATA_WIDTH-1:0]                rd_data,
  input  logic [NUM_PORTS-1:0]                 wr_req,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wr_data,
  output logic [NUM_PORTS-1:0]                 wr_gnt,
  output logic                                 ram_rd_en,
  output logic [ADDR_WIDTH-1:0]                ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]                ram_rd_data,
  output logic                                 ram_wr_en,
  output logic [ADDR_WIDTH-1:0]                ram_wr_addr,
  output logic [DATA_WIDTH-1:0]                ram_wr_data
`ifdef RAM_ARB_PERF_CNT_EN
  ,
  output logic [NUM_PORTS-1:0][31:0]           rd_grant_cnt,
  output logic [NUM_PORTS-1:0][31:0]           wr_grant_cnt,
  output logic [31:0]                          rd_conflict_cnt
`endif
);

  localparam int L    = 1 + int'(REG_RD_DATA);
  localparam int ID_W = $clog2(NUM_PORTS);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rsp_tag_t;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rd_arb (
    .clk (clk), .rst (rst), .req (rd_req), .gnt (rd_gnt)
  );

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_wr_arb (
    .clk (clk), .rst (rst), .req (wr_req), .gnt (wr_gnt)
  );

  // Write path: AND-OR mux on the one-hot grant, zero when idle.
  always_comb begin
    ram_wr_en   = |wr_req;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (wr_gnt[i]) begin
        ram_wr_addr = wr_addr[i];
        ram_wr_data = wr_data[i];
      end
    end
  end

  // Read issue
  logic [MAX_PORTS-1:0] rd_gnt_ext;
  logic [ID_W-1:0]      rd_id;
  logic                 adv_pending;

  always_comb begin
    rd_gnt_ext                = '0;
    rd_gnt_ext[NUM_PORTS-1:0] = rd_gnt;
    rd_id                     = ID_W'(onehot_to_idx(rd_gnt_ext));
    ram_rd_addr               = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rd_gnt[i]) ram_rd_addr = rd_addr[i];
    end
  end

  // Response tag pipeline, one stage per cycle of RAM read latency.
  rsp_tag_t tag_q [L];
  rsp_tag_t tag_d [L];

  assign tag_d[0] = {|rd_req, rd_id};
  for (genvar gi = 1; gi < L; gi++) begin : g_shift
    assign tag_d[gi] = tag_q[gi-1];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < L; i++) begin
      if (rst) tag_q[i] <= '0;
      else     tag_q[i] <= tag_d[i];
    end
  end

  // The RAM output register only moves on rd_en, so keep reading (address 0,
  // result untracked) while any earlier stage still holds a live response.
  always_comb begin
    adv_pending = 1'b0;
    for (int i = 0; i < L - 1; i++) adv_pending = adv_pending | tag_q[i].valid;
  end

  assign ram_rd_en = (|rd_req) | adv_pending;
  assign rd_data   = ram_rd_data;

  always_comb begin
    rd_valid = '0;
    if (tag_q[L-1].valid) rd_valid[tag_q[L-1].id] = 1'b1;
  end

`ifdef RAM_ARB_PERF_CNT_EN
  logic [NUM_PORTS-1:0][31:0] rd_cnt_q, wr_cnt_q;
  logic [31:0]                conflict_q;
  logic                       rd_conflict;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign rd_conflict = |(rd_req & (rd_req - NUM_PORTS'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      conflict_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (rd_gnt[i] && (rd_cnt_q[i] != '1)) rd_cnt_q[i] <= rd_cnt_q[i] + 32'd1;
        if (wr_gnt[i] && (wr_cnt_q[i] != '1)) wr_cnt_q[i] <= wr_cnt_q[i] + 32'd1;
      end
      if (rd_conflict && (conflict_q != '1)) conflict_q <= conflict_q + 32'd1;
    end
  end

  assign rd_grant_cnt    = rd_cnt_q;
  assign wr_grant_cnt    = wr_cnt_q;
  assign rd_conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_ram_sdp_arbiter.sv
// tb_ram_sdp_arbiter: table-driven check of ram_sdp_arbiter (REG_RD_DATA=1)
// against a behavioural ram_sdp model, plus hand-written sequences for
// write readback, reset mid-flight, REG_RD_DATA=0 latency and (when
// RAM_ARB_PERF_CNT_EN is defined) the performance counters.
module tb_ram_sdp_arbiter;

  localparam int NP = 4;
  localparam int DW = 16;
  localparam int AW = 10;

  // Fixed per-requester addresses/data used by the vector table.
  localparam logic [AW-1:0] RA [NP] = '{10'h012, 10'h011, 10'h010, 10'h013};
  localparam logic [DW-1:0] RD [NP] = '{16'hA000, 16'hA001, 16'hBEEF, 16'hA003};
  localparam logic [AW-1:0] WA [NP] = '{10'h007, 10'h005, 10'h008, 10'h006};
  localparam logic [DW-1:0] WD [NP] = '{16'h7777, 16'h1234, 16'h8888, 16'h5678};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NP-1:0]         rd_req, wr_req, rd_gnt, rd_valid, wr_gnt;
  logic [NP-1:0][AW-1:0] rd_addr, wr_addr;
  logic [NP-1:0][DW-1:0] wr_data;
  logic [DW-1:0]         rd_data, ram_rd_data, ram_wr_data;
  logic                  ram_rd_en, ram_wr_en;
  logic [AW-1:0]         ram_rd_addr, ram_wr_addr;

  // Second instance with REG_RD_DATA=0, read-only.
  logic [NP-1:0]         rd_req0, wr_req0, rd_gnt0, rd_valid0, wr_gnt0;
  logic [DW-1:0]         rd_data0, ram_rd_data0, ram_wr_data0;
  logic                  ram_rd_en0, ram_wr_en0;
  logic [AW-1:0]         ram_rd_addr0, ram_wr_addr0;

`ifdef RAM_ARB_PERF_CNT_EN
  logic [NP-1:0][31:0] rd_grant_cnt, wr_grant_cnt, rd_grant_cnt0, wr_grant_cnt0;
  logic [31:0]         rd_conflict_cnt, rd_conflict_cnt0;
`endif

  ram_sdp_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_RD_DATA(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
`ifdef RAM_ARB_PERF_CNT_EN
    , .rd_grant_cnt(rd_grant_cnt), .wr_grant_cnt(wr_grant_cnt), .rd_conflict_cnt(rd_conflict_cnt)
`endif
  );

  ram_sdp_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_RD_DATA(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .rd_req(rd_req0), .rd_addr(rd_addr), .rd_gnt(rd_gnt0), .rd_valid(rd_valid0), .rd_data(rd_data0),
    .wr_req(wr_req0), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt0),
    .ram_rd_en(ram_rd_en0), .ram_rd_addr(ram_rd_addr0), .ram_rd_data(ram_rd_data0),
    .ram_wr_en(ram_wr_en0), .ram_wr_addr(ram_wr_addr0), .ram_wr_data(ram_wr_data0)
`ifdef RAM_ARB_PERF_CNT_EN
    , .rd_grant_cnt(rd_grant_cnt0), .wr_grant_cnt(wr_grant_cnt0), .rd_conflict_cnt(rd_conflict_cnt0)
`endif
  );

  // Behavioural ram_sdp: both read stages advance only on rd_en.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ram_s1_q, ram_out_q, ram0_s1_q;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en)          mem[pl_addr] <= pl_data;
    else if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) begin
      ram_s1_q  <= mem[ram_rd_addr];
      ram_out_q <= ram_s1_q;
    end
    if (ram_rd_en0) ram0_s1_q <= mem[ram_rd_addr0];
  end
  assign ram_rd_data  = ram_out_q;
  assign ram_rd_data0 = ram0_s1_q;

  typedef struct {
    logic          rst;
    logic [NP-1:0] rd_req;
    logic [NP-1:0] wr_req;
    logic [NP-1:0] e_rd_gnt;
    logic [NP-1:0] e_wr_gnt;
    logic          e_rd_en;
    logic [NP-1:0] e_rd_valid;
    logic [DW-1:0] e_rd_data;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic r, input logic [NP-1:0] rq, input logic [NP-1:0] wq,
                              input logic [NP-1:0] erg, input logic [NP-1:0] ewg, input logic ere,
                              input logic [NP-1:0] erv, input logic [DW-1:0] erd);
    vec_t v;
    v.rst = r; v.rd_req = rq; v.wr_req = wq; v.e_rd_gnt = erg; v.e_wr_gnt = ewg;
    v.e_rd_en = ere; v.e_rd_valid = erv; v.e_rd_data = erd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [AW-1:0] e_ra, e_wa;
    logic [DW-1:0] e_wd;
    logic          ok;
    rst = v.rst; rd_req = v.rd_req; wr_req = v.wr_req;
    @(negedge clk);
    e_ra = '0; e_wa = '0; e_wd = '0;
    for (int p = 0; p < NP; p++) begin
      if (v.e_rd_gnt[p]) e_ra = RA[p];
      if (v.e_wr_gnt[p]) begin e_wa = WA[p]; e_wd = WD[p]; end
    end
    ok = (rd_gnt === v.e_rd_gnt) && (wr_gnt === v.e_wr_gnt) && (ram_rd_en === v.e_rd_en) &&
         (ram_rd_addr === e_ra) && (rd_valid === v.e_rd_valid) && (ram_wr_en === (|v.wr_req)) &&
         (ram_wr_addr === e_wa) && (ram_wr_data === e_wd) &&
         ((v.e_rd_valid == '0) || (rd_data === v.e_rd_data));
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL vec%0d: rd_gnt=%b/%b wr_gnt=%b/%b rd_en=%b/%b rd_addr=%h/%h rd_valid=%b/%b rd_data=%h/%h wr_en=%b wr_addr=%h/%h wr_data=%h/%h (got/expected)",
               n, rd_gnt, v.e_rd_gnt, wr_gnt, v.e_wr_gnt, ram_rd_en, v.e_rd_en, ram_rd_addr, e_ra,
               rd_valid, v.e_rd_valid, rd_data, v.e_rd_data, ram_wr_en, ram_wr_addr, e_wa, ram_wr_data, e_wd);
    end else begin
      $display("ok   vec%0d rd_gnt=%b wr_gnt=%b rd_valid=%b rd_data=%h", n, rd_gnt, wr_gnt, rd_valid, rd_data);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rd_req = '0; wr_req = '0; rd_req0 = '0; wr_req0 = '0;
    for (int p = 0; p < NP; p++) begin
      rd_addr[p] = RA[p]; wr_addr[p] = WA[p]; wr_data[p] = WD[p];
    end
    pl_en = 1'b1; pl_addr = '0; pl_data = '0;
    tick();
    for (int p = 0; p < NP; p++) begin
      pl_addr = RA[p]; pl_data = RD[p];
      tick();
    end
    pl_en = 1'b0;

    //                rst   rd_req   wr_req   e_rd_gnt e_wr_gnt en    e_rd_valid data
    vq.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 16'h0));    // 0 reset
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 16'h0));    // 1 idle
    vq.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b1, 4'b0000, 16'h0));    // 2 single read
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 16'h0));    // 3 advance read
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0100, 16'hBEEF)); // 4 response
    vq.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 16'h0));    // 5 reset ptrs
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b1, 4'b0000, 16'h0));    // 6 all read
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b0000, 16'h0));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 1'b1, 4'b0001, 16'hA000));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 1'b1, 4'b0010, 16'hA001));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b1, 4'b0100, 16'hBEEF));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b1000, 16'hA003));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 1'b1, 4'b0001, 16'hA000));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 1'b1, 4'b0010, 16'hA001)); // 13
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0100, 16'hBEEF)); // 14 drain
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1000, 16'hA003));
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 16'h0));
    vq.push_back(mk(1'b0, 4'b0000, 4'b1010, 4'b0000, 4'b0010, 1'b0, 4'b0000, 16'h0));    // 17 wr 1 first
    vq.push_back(mk(1'b0, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 4'b0000, 16'h0));    // 18 wr 3 next
    vq.push_back(mk(1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 1'b1, 4'b0000, 16'h0));    // 19 rd+wr same port
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 16'h0));
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 16'hA001));
    vq.push_back(mk(1'b0, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b1, 4'b0000, 16'h0));    // 22 ptr 2 wraps to 0
    vq.push_back(mk(1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b0000, 16'h0));
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0001, 16'hA000));
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 16'hA001));
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 16'h0));
    vq.push_back(mk(1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0100, 1'b0, 4'b0000, 16'h0));    // 27 wr ptr 2
    vq.push_back(mk(1'b0, 4'b0000, 4'b1011, 4'b0000, 4'b1000, 1'b0, 4'b0000, 16'h0));
    vq.push_back(mk(1'b0, 4'b0000, 4'b0011, 4'b0000, 4'b0001, 1'b0, 4'b0000, 16'h0));
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 16'h0));

    for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

    // Readback of the writes to addresses 5 and 6 (read pointer is at 2).
    rd_addr[0] = 10'h005; rd_req = 4'b0001;
    @(negedge clk); chk("wb_gnt0", 32'(rd_gnt), 32'h1); chk("wb_addr0", 32'(ram_rd_addr), 32'h5);
    tick();
    rd_addr[1] = 10'h006; rd_req = 4'b0010;
    @(negedge clk); chk("wb_gnt1", 32'(rd_gnt), 32'h2);
    tick();
    rd_req = '0;
    @(negedge clk); chk("wb_valid0", 32'(rd_valid), 32'h1); chk("wb_data0", 32'(rd_data), 32'h1234);
    tick();
    @(negedge clk); chk("wb_valid1", 32'(rd_valid), 32'h2); chk("wb_data1", 32'(rd_data), 32'h5678);
    tick();
    rd_addr[0] = RA[0]; rd_addr[1] = RA[1];

    // Reset one cycle after a grant: the response is discarded and both
    // pointers (read at 3, write at 1 beforehand) return to 0.
    rd_req = 4'b0100;
    @(negedge clk); chk("rst_gnt", 32'(rd_gnt), 32'h4);
    tick();
    rd_req = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk); chk("rst_valid_a", 32'(rd_valid), 32'h0); chk("rst_rd_en", 32'(ram_rd_en), 32'h0);
    tick();
    rd_req = 4'b1111; wr_req = 4'b1111;
    @(negedge clk);
    chk("rst_valid_b", 32'(rd_valid), 32'h0);
    chk("rst_rd_ptr", 32'(rd_gnt), 32'h1);
    chk("rst_wr_ptr", 32'(wr_gnt), 32'h1);
    tick();
    rd_req = '0; wr_req = '0;
    tick(); tick(); tick();

    // REG_RD_DATA=0 instance: latency 1, no extra advance read.
    rd_req0 = 4'b0100;
    @(negedge clk); chk("l1_gnt", 32'(rd_gnt0), 32'h4); chk("l1_rd_en", 32'(ram_rd_en0), 32'h1);
    tick();
    rd_req0 = '0;
    @(negedge clk);
    chk("l1_valid", 32'(rd_valid0), 32'h4);
    chk("l1_data", 32'(rd_data0), 32'hBEEF);
    chk("l1_rd_en_off", 32'(ram_rd_en0), 32'h0);
    tick();
    @(negedge clk); chk("l1_valid_off", 32'(rd_valid0), 32'h0);
    tick();

`ifdef RAM_ARB_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk); chk("pc_reset", rd_conflict_cnt, 32'h0);
    tick();
    rd_req = 4'b0011;
    for (int c = 0; c < 10; c++) tick();
    rd_req = '0;
    @(negedge clk);
    chk("pc_rd0", rd_grant_cnt[0], 32'd5);
    chk("pc_rd1", rd_grant_cnt[1], 32'd5);
    chk("pc_conflict", rd_conflict_cnt, 32'd10);
    chk("pc_wr0", wr_grant_cnt[0], 32'd0);
    tick(); tick(); tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
